bresenham_line_engine: RTL and testbench
========================================

# bresenham_line_engine

Rasterizes one line segment per command using integer Bresenham stepping and emits one pixel coordinate per accepted handshake. It sits directly downstream of the Bresenham controller. It latches the endpoint pair presented with the controller's one-cycle `draw_en` pulse, then streams pixels to the framebuffer writer. When the last pixel has been accepted, it returns a one-cycle `draw_done` pulse, which lets the controller advance to the next edge.

## Interface
Parameters:
- COORD_W, 8, coordinate width in bits; all arithmetic widths below derive from it.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  synchronous, active-high reset. The name is kept for codebase consistency; 1 = reset, sampled on the rising clk edge.
- draw_en  input  1  one-cycle start pulse from the controller; endpoints are valid only in this cycle.
- x0, y0  input  COORD_W  start point (unsigned).
- x1, y1  input  COORD_W  end point (unsigned).
- pixel_ready  input  1  the downstream writer can accept a pixel this cycle.
- pixel_valid  output  1  `pixel_x`/`pixel_y` hold a valid pixel.
- pixel_x, pixel_y  output  COORD_W  current pixel coordinate.
- busy  output  1  high in PLOT and DONE.
- draw_done  output  1  one-cycle pulse after the final pixel is accepted.

## Operation
- States:
  - IDLE: waits for a command.
  - PLOT: emits pixels.
  - DONE: pulses `draw_done` for one cycle.
- Reset forces IDLE and drives all outputs to 0: `pixel_valid`, `pixel_x`, `pixel_y`, `busy`, `draw_done`. Internal registers also clear to 0.
- IDLE, `draw_en`=1: latch the command and go to PLOT.
  - cur = (x0, y0), end = (x1, y1).
  - dx = |x1-x0| (COORD_W bits).
  - dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx + dy.
  - err, dx and dy are held as COORD_W+2-bit signed values. e2 = 2·err is COORD_W+3-bit signed.
- `draw_en` outside IDLE is ignored; the in-flight line is unaffected.
- PLOT: `pixel_valid`=1 and `pixel_x`/`pixel_y` = cur. A pixel is accepted when `pixel_valid` and `pixel_ready` are both 1.
  - If cur == end at acceptance, go to DONE.
  - Otherwise compute e2 = 2·err, then apply both updates, each using the err value from before the step:
    - if e2 ≥ dy: err += dy and x += sx;
    - if e2 ≤ dx: err += dx and y += sy.
  - When both updates apply, err receives dx+dy in total.
- While `pixel_ready`=0, `pixel_x`, `pixel_y` and all internal state hold unchanged.
- DONE: `draw_done`=1 and `pixel_valid`=0 for exactly one cycle, then go to IDLE.
- Pixel count per line is max(dx, |dy|)+1. A degenerate line (start == end) emits exactly one pixel.
- Coordinates never wrap. Stepping stops exactly at end, so 0 and 2^COORD_W−1 are legal endpoints with no overflow.

## Timing
- `draw_en` sampled in cycle N. The first pixel is valid in cycle N+1.
- With `pixel_ready` held at 1, one pixel is emitted per cycle.
- The last pixel is accepted in cycle N+P, where P is the pixel count. `draw_done` is high in cycle N+P+1. The block is in IDLE and accepts a new `draw_en` in cycle N+P+2.
- `busy` is high from N+1 through N+P+1 inclusive.
- Reset asserted in any state takes effect on the next edge and the line is aborted. No `draw_done` is generated for an aborted line.
- `draw_en` coincident with reset: reset wins and the command is dropped.

## Test plan
- Point line (5,5)→(5,5), `draw_en` in cycle 0, ready=1 → single pixel (5,5) in cycle 1; `draw_done`=1 in cycle 2 only; busy=0 in cycle 3.
- Horizontal line (0,0)→(3,0), ready=1 → pixels (0,0),(1,0),(2,0),(3,0) in cycles 1–4; `draw_done` in cycle 5.
- Steep line (0,0)→(1,3) → pixels (0,0),(0,1),(1,2),(1,3). Reverse diagonal (255,255)→(0,0) → 256 pixels, x=y decreasing from 255 to 0, no wrap; `draw_done` in cycle 257.
- Backpressure: line (0,0)→(3,0) with ready=0 in cycles 2–4 → (1,0) held stable in cycles 2–5; sequence completes with `draw_done` in cycle 8.
- `draw_en` pulsed again with (9,9)→(9,9) in cycle 2 of a 4-pixel line → ignored; the original pixel sequence and `draw_done` timing are unchanged.
- Reset asserted in cycle 2 of line (0,0)→(3,0) → cycle 3: all outputs 0 and IDLE, no `draw_done`. A new `draw_en` in cycle 4 gives its first pixel in cycle 5.

Source files
------------

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasterizer: latches one endpoint pair per draw_en pulse and
// streams one pixel per valid/ready handshake, then pulses draw_done.
module bresenham_line_engine #(
  parameter int unsigned COORD_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               draw_en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               pixel_ready,
  output logic               pixel_valid,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               busy,
  output logic               draw_done
);

  localparam int unsigned ERR_W = COORD_W + 2;
  localparam int unsigned E2_W  = COORD_W + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [COORD_W-1:0]      end_x;
  logic [COORD_W-1:0]      end_y;
  logic signed [ERR_W-1:0] dx;
  logic signed [ERR_W-1:0] dy;
  logic signed [ERR_W-1:0] err;
  logic                    sx_pos;
  logic                    sy_pos;

  logic                    accept;
  logic                    at_end;
  logic signed [E2_W-1:0]  e2;
  logic                    step_x;
  logic                    step_y;
  logic signed [ERR_W-1:0] err_step;

  logic [COORD_W-1:0]      adx;
  logic [COORD_W-1:0]      ady;
  logic signed [ERR_W-1:0] dx_init;
  logic signed [ERR_W-1:0] dy_init;

  logic                    valid_next;
  logic                    busy_next;
  logic                    done_next;

  // Command setup: absolute deltas, dy carried as a negative quantity
  always_comb begin
    adx     = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    ady     = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    dx_init = $signed({2'b00, adx});
    dy_init = -$signed({2'b00, ady});
  end

  // Stepping decisions, both taken against the pre-step error
  always_comb begin
    accept   = (state == PLOT) && pixel_ready;
    at_end   = (pixel_x == end_x) && (pixel_y == end_y);
    e2       = $signed({err, 1'b0});
    step_x   = e2 >= $signed({dy[ERR_W-1], dy});
    step_y   = e2 <= $signed({dx[ERR_W-1], dx});
    err_step = err;
    if (step_x) err_step = err_step + dy;
    if (step_y) err_step = err_step + dx;
  end

  // State register plus registered control outputs
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state       <= IDLE;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      draw_done   <= 1'b0;
    end else begin
      state       <= state_next;
      pixel_valid <= valid_next;
      busy        <= busy_next;
      draw_done   <= done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (draw_en) state_next = PLOT;
      PLOT:    if (accept && at_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode, looked ahead by one state so the outputs can be registered
  always_comb begin
    valid_next = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_next)
      PLOT: begin
        valid_next = 1'b1;
        busy_next  = 1'b1;
      end
      DONE: begin
        busy_next = 1'b1;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Line datapath: latch on command, step on accepted non-final pixel
  always_ff @(posedge clk) begin
    if (n_rst) begin
      pixel_x <= '0;
      pixel_y <= '0;
      end_x   <= '0;
      end_y   <= '0;
      dx      <= '0;
      dy      <= '0;
      err     <= '0;
      sx_pos  <= 1'b0;
      sy_pos  <= 1'b0;
    end else if ((state == IDLE) && draw_en) begin
      pixel_x <= x0;
      pixel_y <= y0;
      end_x   <= x1;
      end_y   <= y1;
      dx      <= dx_init;
      dy      <= dy_init;
      err     <= dx_init + dy_init;
      sx_pos  <= x0 < x1;
      sy_pos  <= y0 < y1;
    end else if (accept && !at_end) begin
      err <= err_step;
      if (step_x) pixel_x <= sx_pos ? (pixel_x + COORD_W'(1)) : (pixel_x - COORD_W'(1));
      if (step_y) pixel_y <= sy_pos ? (pixel_y + COORD_W'(1)) : (pixel_y - COORD_W'(1));
    end
  end

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Scoreboard bench for bresenham_line_engine: directed plan cases plus random
// lines with random backpressure, checked against an integer line model.
module tb_bresenham_line_engine;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       draw_en;
  logic [7:0] x0, y0, x1, y1;
  logic       pixel_ready;
  logic       pixel_valid;
  logic [7:0] pixel_x, pixel_y;
  logic       busy;
  logic       draw_done;

  bresenham_line_engine #(.COORD_W(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .draw_en    (draw_en),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .pixel_ready(pixel_ready),
    .pixel_valid(pixel_valid),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .busy       (busy),
    .draw_done  (draw_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   ready_mode = 0;
  bit   exp_done = 1'b0;
  bit   hold_valid = 1'b0;
  int   hold_x, hold_y;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference line: integer Bresenham from the endpoint rules
  task automatic model_push(input int ax0, input int ay0, input int ax1, input int ay1);
    int dxm, dym, sx, sy, err, e2, x, y;
    bit last;
    dxm = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dym = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dxm + dym;
    x = ax0;
    y = ay0;
    for (int i = 0; i < 1024; i++) begin
      last = (x == ax1) && (y == ay1);
      exp_q.push_back('{x, y, last});
      if (last) break;
      e2 = 2 * err;
      if (e2 >= dym) begin err += dym; x += sx; end
      if (e2 <= dxm) begin err += dxm; y += sy; end
    end
  endtask

  // Random backpressure source
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) pixel_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 0) pixel_ready = 1'b1;
  end

  // Monitor: compares accepted pixels, hold behaviour and draw_done timing
  always @(negedge clk) begin
    pix_t p;
    if (n_rst) begin
      exp_q.delete();
      exp_done   = 1'b0;
      hold_valid = 1'b0;
    end else begin
      chk("draw_done", int'(draw_done), int'(exp_done));
      exp_done = 1'b0;
      if (draw_done) chk("valid_in_done", int'(pixel_valid), 0);
      if (hold_valid && pixel_valid) begin
        chk("hold_x", int'(pixel_x), hold_x);
        chk("hold_y", int'(pixel_y), hold_y);
      end
      hold_valid = 1'b0;
      if (pixel_valid && pixel_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pixel_x, pixel_y);
        end else begin
          p = exp_q.pop_front();
          chk("pixel_x", int'(pixel_x), p.x);
          chk("pixel_y", int'(pixel_y), p.y);
          if (p.last) exp_done = 1'b1;
        end
      end else if (pixel_valid) begin
        hold_valid = 1'b1;
        hold_x     = pixel_x;
        hold_y     = pixel_y;
      end
    end
  end

  int t0;

  // Issue a command in cycle N; check busy and the first pixel in cycle N+1
  task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1);
    @(posedge clk);
    #1;
    t0 = cyc_cnt;
    x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1);
    draw_en = 1'b1;
    model_push(ax0, ay0, ax1, ay1);
    @(posedge clk);
    #1;
    draw_en = 1'b0;
    @(negedge clk);
    chk("first_valid", int'(pixel_valid), 1);
    chk("first_x", int'(pixel_x), ax0);
    chk("first_y", int'(pixel_y), ay0);
    chk("first_busy", int'(busy), 1);
  endtask

  // Wait (bounded) for draw_done; returns its cycle relative to N
  task automatic wait_done(output int rel);
    int k;
    k = 0;
    while (!draw_done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!draw_done) chk("done_timeout", 0, 1);
    else chk("busy_at_done", int'(busy), 1);
    rel = cyc_cnt - t0;
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(pixel_valid), 0);
    chk({tag, "_x"}, int'(pixel_x), 0);
    chk({tag, "_y"}, int'(pixel_y), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(draw_done), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rel;
    int ax0, ay0, ax1, ay1;
    n_rst = 1'b1;
    draw_en = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    pixel_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b0;

    // Point line
    start_line(5, 5, 5, 5);
    wait_done(rel);
    chk("point_done_cycle", rel, 2);

    // Horizontal line
    start_line(0, 0, 3, 0);
    wait_done(rel);
    chk("horiz_done_cycle", rel, 5);

    // Steep line
    start_line(0, 0, 1, 3);
    wait_done(rel);
    chk("steep_done_cycle", rel, 5);

    // Reverse full diagonal, no wrap at 0
    start_line(255, 255, 0, 0);
    wait_done(rel);
    chk("diag_done_cycle", rel, 257);

    // Backpressure: ready low in cycles 2-4
    ready_mode = 2;
    pixel_ready = 1'b1;
    start_line(0, 0, 3, 0);
    @(posedge clk);
    #1;
    pixel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pixel_ready = 1'b1;
    @(negedge clk);
    chk("bp_held_x", int'(pixel_x), 1);
    wait_done(rel);
    chk("bp_done_cycle", rel, 8);
    ready_mode = 0;

    // draw_en while busy is ignored
    start_line(0, 0, 3, 0);
    @(posedge clk);
    #1;
    x0 = 8'd9; y0 = 8'd9; x1 = 8'd9; y1 = 8'd9;
    draw_en = 1'b1;
    @(posedge clk);
    #1;
    draw_en = 1'b0;
    wait_done(rel);
    chk("ignored_done_cycle", rel, 5);

    // Reset mid-line aborts it; next command starts cleanly
    start_line(0, 0, 3, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    start_line(2, 7, 6, 4);
    wait_done(rel);
    chk("post_abort_done_cycle", rel, 6);

    // draw_en coincident with reset is dropped
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    x0 = 8'd1; y0 = 8'd1; x1 = 8'd4; y1 = 8'd4;
    draw_en = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    draw_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_cmd_valid", int'(pixel_valid), 0);
      chk("rst_cmd_busy", int'(busy), 0);
    end

    // Random lines with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) begin
        ax0 = $urandom_range(0, 255); ay0 = $urandom_range(0, 255);
        ax1 = $urandom_range(0, 255); ay1 = $urandom_range(0, 255);
      end else begin
        ax0 = $urandom_range(0, 12); ay0 = $urandom_range(243, 255);
        ax1 = $urandom_range(0, 12); ay1 = $urandom_range(243, 255);
      end
      start_line(ax0, ay0, ax1, ay1);
      wait_done(rel);
      chk("rand_queue_empty", exp_q.size(), 0);
    end
    ready_mode = 0;

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
